// File: rtl/serial_output_pkg.sv
// Shared definitions for the serial_output UART transmitter: state encoding,
// frame geometry and small elaboration-time helpers.
// Optional feature macro: SERIAL_OUTPUT_PARITY_EN (even parity bit after DATA).
package serial_output_pkg;

  // Transmitter state encoding; PARITY is only ever entered when the parity
  // feature is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Frame geometry in line bits.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Clock cycles per line bit; guards against a zero or over-fast baud rate so
  // the divider never collapses below one cycle per bit.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    if (baud == 0 || clk_hz < baud) return 1;
    return clk_hz / baud;
  endfunction

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned counter_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_output_baud_tick.sv
// baud_tick: free-running bit-period counter for serial_output. Counts
// 0..DIVISOR-1 and pulses tick for one cycle on the last count of each bit
// period. While restart is high the counter is held at 0, so the first cycle
// after restart drops is count 0 of a fresh bit period.
// Optional feature macro: SERIAL_OUTPUT_PARITY_EN (not used in this file).
module baud_tick
  import serial_output_pkg::*;
#(
  parameter int unsigned DIVISOR = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = counter_width(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  // Bit-period counter with synchronous active-low reset and restart.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/serial_output.sv
// serial_output: 8N1 UART transmitter fed by a stb/ack stream interface.
// A word is accepted on an edge where input_data_stb and input_data_ack are
// both high; input_data[7:0] is then sent as start bit, 8 data bits LSB first
// and one stop bit, each held for CLOCK_FREQUENCY/BAUD_RATE cycles.
// Optional feature macro: SERIAL_OUTPUT_PARITY_EN inserts an even parity bit
// between the data bits and the stop bit.
module serial_output
  import serial_output_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_data,
  input  logic        input_data_stb,
  output logic        input_data_ack,
  output logic        tx
);

  localparam int unsigned DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   data_q;
  logic [2:0]             bit_idx;
  logic                   tx_q;
  logic                   ack_q;
  logic                   transfer;
  logic                   restart;
  logic                   tick;

  // Only the low byte is transmitted; the upper bits are deliberately dropped.
  logic unused_upper_bits;
  assign unused_upper_bits = ^input_data[31:8];

  // ack_q is only ever high in IDLE, so this is the single acceptance point.
  assign transfer = input_data_stb && ack_q;

  // Hold the bit timer at zero while idle so START begins a full bit period.
  assign restart = (state == IDLE);

  baud_tick #(
    .DIVISOR (DIVISOR)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Frame sequencer: registered tx and ack advance one line bit per tick.
  // NOTE: the latched byte is reset along with the control state so an aborted
  // frame leaves no stale data visible after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      bit_idx <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            data_q  <= input_data[DATA_BITS-1:0];
            state   <= START;
            tx_q    <= 1'b0;
            ack_q   <= 1'b0;
            bit_idx <= '0;
          end else begin
            tx_q  <= 1'b1;
            ack_q <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            state   <= DATA;
            tx_q    <= data_q[0];
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA_IDX) begin
              bit_idx <= '0;
`ifdef SERIAL_OUTPUT_PARITY_EN
              state   <= PARITY;
              tx_q    <= even_parity(data_q);
`else
              state   <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= data_q[bit_idx + 3'd1];
            end
          end
        end

`ifdef SERIAL_OUTPUT_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx_q  <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP_IDX) begin
              state   <= IDLE;
              tx_q    <= 1'b1;
              ack_q   <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          tx_q    <= 1'b1;
          ack_q   <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  assign tx             = tx_q;
  assign input_data_ack = ack_q;

endmodule

// File: tb/tb_serial_output.sv
// Self-checking bench for serial_output with DIVISOR = 16.
// A frame-level reference model (queue of expected line samples) is compared
// against tx and input_data_ack on every falling edge; directed tests add
// hand-computed frame patterns and lengths.
module tb_serial_output;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned BAUD   = 1;
  localparam int          D      = 16;

`ifdef SERIAL_OUTPUT_PARITY_EN
  localparam int NBITS   = 11;
  localparam int EXP_LEN = 176;
  // Line bits packed with bit 0 = start bit: {stop, parity, data, start}.
  localparam logic [10:0] F55 = 11'h4AA;
  localparam logic [10:0] FA3 = 11'h546;
  localparam logic [10:0] F41 = 11'h482;
  localparam logic [10:0] F42 = 11'h484;
  localparam logic [10:0] F3C = 11'h478;
  localparam logic [10:0] F07 = 11'h60E;
  localparam logic [10:0] F03 = 11'h406;
`else
  localparam int NBITS   = 10;
  localparam int EXP_LEN = 160;
  // Line bits packed with bit 0 = start bit: {stop, data, start}.
  localparam logic [10:0] F55 = 11'h2AA;
  localparam logic [10:0] FA3 = 11'h346;
  localparam logic [10:0] F41 = 11'h282;
  localparam logic [10:0] F42 = 11'h284;
  localparam logic [10:0] F3C = 11'h278;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_data = '0;
  logic        input_data_stb = 1'b0;
  logic        input_data_ack;
  logic        tx;

  serial_output #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .input_data     (input_data),
    .input_data_stb (input_data_stb),
    .input_data_ack (input_data_ack),
    .tx             (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_tx   = 1'b1;
  bit m_ack  = 1'b0;
  bit m_busy = 1'b0;
  bit mq[$];

  function automatic void push_bit(input bit b);
    for (int k = 0; k < D; k++) mq.push_back(b);
  endfunction

  function automatic void build_frame(input logic [7:0] b);
    int ones = 0;
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      push_bit(b[i]);
      if (b[i]) ones++;
    end
`ifdef SERIAL_OUTPUT_PARITY_EN
    push_bit((ones % 2) == 1);
`endif
    push_bit(1'b1);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0;
      mq.delete();
      m_tx  = 1'b1;
      m_ack = 1'b0;
    end else if (m_busy) begin
      if (mq.size() > 0) begin
        m_tx = mq.pop_front();
      end else begin
        m_busy = 1'b0;
        m_tx   = 1'b1;
        m_ack  = 1'b1;
      end
    end else if (input_data_stb && m_ack) begin
      build_frame(input_data[7:0]);
      m_tx   = mq.pop_front();
      m_busy = 1'b1;
      m_ack  = 1'b0;
    end else begin
      m_tx  = 1'b1;
      m_ack = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("model_tx", {31'd0, tx}, {31'd0, m_tx});
    check("model_ack", {31'd0, input_data_ack}, {31'd0, m_ack});
  end

  // ---------------- stimulus helpers ----------------
  // Presents a word and returns just after the edge on which it was accepted.
  task automatic send_word(input logic [31:0] w, input bit hold, output int waited);
    input_data     = w;
    input_data_stb = 1'b1;
    waited         = 0;
    while (input_data_ack !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) check("send_timeout", {31'd0, input_data_ack}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) input_data_stb = 1'b0;
  endtask

  // Samples each line bit mid-period; len is cycles from first start-bit
  // cycle to the first cycle with ack high again.
  task automatic capture(output logic [10:0] bits, output int len);
    int idx;
    bits = '0;
    len  = -1;
    for (int c = 1; c <= EXP_LEN + D; c++) begin
      @(negedge clk);
      idx = (c - 1) / D;
      if ((c % D) == D / 2 && idx < NBITS) bits[idx] = tx;
      if (input_data_ack === 1'b1) begin
        len = c - 1;
        break;
      end
    end
  endtask

  task automatic frame_test(input string name, input logic [31:0] w, input logic [10:0] exp_bits);
    int          wt;
    int          len;
    logic [10:0] b;
    send_word(w, 1'b0, wt);
    capture(b, len);
    check({name, "_bits"}, {21'd0, b}, {21'd0, exp_bits});
    check({name, "_len"}, len, EXP_LEN);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          wt;
    int          len;
    int          zeros;
    int          acks;
    logic [10:0] b;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ack", {31'd0, input_data_ack}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ack_after_reset", {31'd0, input_data_ack}, 32'd1);

    // Long idle with stb low.
    zeros = 0;
    acks  = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
      if (input_data_ack === 1'b1) acks++;
    end
    check("idle_tx_low_cycles", zeros, 0);
    check("idle_ack_cycles", acks, 1000);

    // Single frames.
    frame_test("w55", 32'h0000_0055, F55);
    frame_test("wA3", 32'hFFFF_FFA3, FA3);

    // Back-to-back with stb held high.
    send_word(32'h0000_0041, 1'b1, wt);
    capture(b, len);
    check("b2b_first_bits", {21'd0, b}, {21'd0, F41});
    check("b2b_first_len", len, EXP_LEN);
    check("b2b_idle_tx", {31'd0, tx}, 32'd1);
    send_word(32'h0000_0042, 1'b0, wt);
    check("b2b_gap_waits", wt, 0);
    check("b2b_second_start_tx", {31'd0, tx}, 32'd0);
    check("b2b_second_start_ack", {31'd0, input_data_ack}, 32'd0);
    capture(b, len);
    check("b2b_second_bits", {21'd0, b}, {21'd0, F42});
    check("b2b_second_len", len, EXP_LEN);

    // Reset at cycle 40 of a 0x00 frame.
    send_word(32'h0000_0000, 1'b0, wt);
    repeat (39) begin
      @(posedge clk);
      #1;
    end
    check("abort_mid_frame_tx", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_ack", {31'd0, input_data_ack}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_release_ack", {31'd0, input_data_ack}, 32'd1);
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("abort_no_retransmit", zeros, 0);
    frame_test("w3C_after_abort", 32'h0000_003C, F3C);

`ifdef SERIAL_OUTPUT_PARITY_EN
    send_word(32'h0000_0007, 1'b0, wt);
    capture(b, len);
    check("par07_bits", {21'd0, b}, {21'd0, F07});
    check("par07_parity_bit", {31'd0, b[9]}, 32'd1);
    check("par07_len", len, 176);
    send_word(32'h0000_0003, 1'b0, wt);
    capture(b, len);
    check("par03_bits", {21'd0, b}, {21'd0, F03});
    check("par03_parity_bit", {31'd0, b[9]}, 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
